// File: rtl/bounce_gen.sv
// Mechanical contact-bounce emulator: replays each level change on levelIn as
// an LFSR-timed burst of glitch pulses before settling on the new level.
module bounce_gen #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned MAX_GLITCH = 4,
  parameter int unsigned GAP_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic bounceEn,
  input  logic levelIn,
  output logic bouncyOut,
  output logic busy,
  output logic settled
);

  typedef enum logic [1:0] {IDLE, BACK, AWAY} state_t;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [GAP_W:0] CNT_ONE = (GAP_W+1)'(1);

  state_t           state, state_n;
  logic [15:0]      lfsr, lfsr_n;
  logic             target, target_n;
  logic             bouncy_n, busy_n, settled_n;
  logic [GAP_W:0]   cnt, cnt_n;
  logic [4:0]       glitches, glitches_n;
  logic [GAP_W:0]   width_ld;
  logic [4:0]       count_ld;
  logic             edge_ev;

  assign lfsr_n   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
  assign width_ld = {1'b0, lfsr[GAP_W-1:0]} + CNT_ONE;
  assign count_ld = 5'(32'(lfsr[7:4]) % MAX_GLITCH) + 5'd1;
  assign edge_ev  = (levelIn != target);

  always_comb begin
    state_n    = state;
    target_n   = target;
    bouncy_n   = bouncyOut;
    busy_n     = busy;
    settled_n  = 1'b0;
    cnt_n      = cnt;
    glitches_n = glitches;
    // A new edge always wins over an expiring pulse or gap in the same cycle.
    if (edge_ev) begin
      target_n = levelIn;
      bouncy_n = levelIn;
      if (bounceEn) begin
        state_n    = BACK;
        glitches_n = count_ld;
        cnt_n      = width_ld;
        busy_n     = 1'b1;
      end else begin
        state_n    = IDLE;
        glitches_n = '0;
        cnt_n      = '0;
        busy_n     = 1'b0;
        settled_n  = 1'b1;
      end
    end else if (state != IDLE) begin
      if (cnt == CNT_ONE) begin
        case (state)
          BACK: begin
            if (glitches != 5'd0) begin
              state_n    = AWAY;
              bouncy_n   = ~target;
              glitches_n = glitches - 5'd1;
              cnt_n      = width_ld;
            end else begin
              state_n   = IDLE;
              busy_n    = 1'b0;
              settled_n = 1'b1;
              cnt_n     = '0;
            end
          end
          AWAY: begin
            state_n  = BACK;
            bouncy_n = target;
            cnt_n    = width_ld;
          end
          default: state_n = IDLE;
        endcase
      end else begin
        cnt_n = cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED_EFF;
      target    <= 1'b0;
      bouncyOut <= 1'b0;
      busy      <= 1'b0;
      settled   <= 1'b0;
      cnt       <= '0;
      glitches  <= '0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      target    <= target_n;
      bouncyOut <= bouncy_n;
      busy      <= busy_n;
      settled   <= settled_n;
      cnt       <= cnt_n;
      glitches  <= glitches_n;
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: three instances (defaults, MAX_GLITCH=1/GAP_W=1, SEED=0)
// checked against a waveform-schedule reference model.
module tb_bounce_gen;

  logic clk = 1'b0;
  logic rst, bounceEn, levelIn;
  logic out_d, busy_d, set_d;
  logic out_s, busy_s, set_s;
  logic out_z, busy_z, set_z;

  always #5 clk = ~clk;

  bounce_gen dut (
    .clk(clk), .rst(rst), .bounceEn(bounceEn), .levelIn(levelIn),
    .bouncyOut(out_d), .busy(busy_d), .settled(set_d)
  );

  bounce_gen #(.MAX_GLITCH(1), .GAP_W(1)) dut_s (
    .clk(clk), .rst(rst), .bounceEn(bounceEn), .levelIn(levelIn),
    .bouncyOut(out_s), .busy(busy_s), .settled(set_s)
  );

  bounce_gen #(.SEED(16'h0000)) dut_z (
    .clk(clk), .rst(rst), .bounceEn(bounceEn), .levelIn(levelIn),
    .bouncyOut(out_z), .busy(busy_z), .settled(set_z)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Expected {bouncyOut, busy, settled} per cycle.
  typedef logic [2:0] wv_t;
  typedef wv_t wave_q_t[$];

  logic [15:0] m_l [3];
  logic        m_tgt [2];
  wv_t         m_cur [2];
  wave_q_t     m_q0, m_q1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Whole output waveform of one bounce event, starting at the accepting edge.
  function automatic wave_q_t build(input logic lvl, input logic [15:0] l0,
                                    input int mg, input int gw);
    wave_q_t w;
    logic [15:0] l;
    int pulses, len;
    bit away, done;
    l      = l0;
    pulses = (int'(l0[7:4]) % mg) + 1;
    len    = int'(l0 & 16'((1 << gw) - 1)) + 1;
    away   = 1'b0;
    done   = 1'b0;
    while (!done) begin
      for (int j = 0; j < len; j++) begin
        w.push_back({away ? ~lvl : lvl, 1'b1, 1'b0});
        l = lfsr_next(l);
      end
      if (away) away = 1'b0;
      else if (pulses > 0) begin
        away = 1'b1;
        pulses--;
      end else begin
        w.push_back({lvl, 1'b0, 1'b1});
        done = 1'b1;
      end
      len = int'(l & 16'((1 << gw) - 1)) + 1;
    end
    return w;
  endfunction

  // One clock edge: advance reference model with the inputs present at the edge.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      wave_q_t q;
      int mg, gw;
      mg = (i == 0) ? 4 : 1;
      gw = (i == 0) ? 3 : 1;
      if (i == 0) q = m_q0; else q = m_q1;
      if (rst) begin
        m_tgt[i] = 1'b0;
        m_cur[i] = 3'b000;
        q.delete();
      end else if (levelIn != m_tgt[i]) begin
        m_tgt[i] = levelIn;
        if (!bounceEn) begin
          q.delete();
          m_cur[i] = {levelIn, 2'b01};
        end else begin
          q = build(levelIn, m_l[i], mg, gw);
          m_cur[i] = q.pop_front();
        end
      end else if (q.size() > 0) begin
        m_cur[i] = q.pop_front();
      end else begin
        m_cur[i][0] = 1'b0;
      end
      if (i == 0) m_q0 = q; else m_q1 = q;
    end
    for (int i = 0; i < 3; i++)
      m_l[i] = rst ? ((i == 2) ? 16'h0001 : 16'hACE1) : lfsr_next(m_l[i]);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bounceEn = 1'b0; levelIn = 1'b0;
    step(); step();
    vectors++;
    if ({out_d, busy_d, set_d, out_s, busy_s, set_s} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 000000",
               {out_d, busy_d, set_d, out_s, busy_s, set_s});
    end
    vectors++;
    if (dut.lfsr !== 16'hACE1) begin
      miscompares++;
      $display("FAIL reset_lfsr got %h want ace1", dut.lfsr);
    end
    vectors++;
    if (dut_z.lfsr !== 16'h0001) begin
      miscompares++;
      $display("FAIL reset_seed_zero got %h want 0001", dut_z.lfsr);
    end
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    int settles = 0;
    bounceEn = 1'b0;
    for (int c = 0; c < 20; c++) begin
      levelIn = (c < 10) ? 1'b1 : 1'b0;
      step();
      settles += int'(set_d);
      vectors++;
      if ({out_d, busy_d, set_d, out_s, busy_s, set_s} !== {m_cur[0], m_cur[1]}) begin
        miscompares++;
        $display("FAIL passthrough c=%0d got %b want %b", c,
                 {out_d, busy_d, set_d, out_s, busy_s, set_s}, {m_cur[0], m_cur[1]});
      end
    end
    vectors++;
    if (settles != 2) begin
      miscompares++;
      $display("FAIL passthrough_settles got %0d want 2", settles);
    end
  endtask

  task automatic test_small();
    int settles = 0, lows = 0;
    logic prev;
    bounceEn = 1'b1;
    levelIn  = 1'b1;
    prev     = out_s;
    for (int c = 0; c < 30; c++) begin
      step();
      settles += int'(set_s);
      if (prev && !out_s) lows++;
      prev = out_s;
      vectors++;
      if ({out_d, busy_d, set_d, out_s, busy_s, set_s} !== {m_cur[0], m_cur[1]}) begin
        miscompares++;
        $display("FAIL small c=%0d got %b want %b", c,
                 {out_d, busy_d, set_d, out_s, busy_s, set_s}, {m_cur[0], m_cur[1]});
      end
    end
    vectors++;
    if (settles != 1 || lows != 1 || out_s !== 1'b1) begin
      miscompares++;
      $display("FAIL small_shape got settles=%0d lows=%0d out=%b want 1 1 1",
               settles, lows, out_s);
    end
    bounceEn = 1'b0; levelIn = 1'b0;
    for (int c = 0; c < 80; c++) step();
  endtask

  task automatic test_reset_release();
    rst = 1'b1; bounceEn = 1'b1; levelIn = 1'b1;
    step();
    rst = 1'b0;
    step();
    vectors++;
    if ({out_d, busy_d} !== 2'b11) begin
      miscompares++;
      $display("FAIL release_edge got %b want 11", {out_d, busy_d});
    end
    for (int c = 0; c < 90; c++) begin
      step();
      vectors++;
      if ({out_d, busy_d, set_d, out_s, busy_s, set_s} !== {m_cur[0], m_cur[1]}) begin
        miscompares++;
        $display("FAIL release c=%0d got %b want %b", c,
                 {out_d, busy_d, set_d, out_s, busy_s, set_s}, {m_cur[0], m_cur[1]});
      end
    end
  endtask

  task automatic test_reversal();
    int settles = 0;
    bit found = 1'b0;
    bounceEn = 1'b0; levelIn = 1'b0;
    step(); step();
    bounceEn = 1'b1; levelIn = 1'b1;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      settles += int'(set_d);
      if (busy_d && !out_d) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reversal_away got no glitch within 200 cycles");
    end
    levelIn = 1'b0;
    step();
    settles += int'(set_d);
    vectors++;
    if ({out_d, busy_d, set_d, out_s, busy_s, set_s} !== {m_cur[0], m_cur[1]} || out_d !== 1'b0) begin
      miscompares++;
      $display("FAIL reversal_edge got %b want %b",
               {out_d, busy_d, set_d, out_s, busy_s, set_s}, {m_cur[0], m_cur[1]});
    end
    for (int c = 0; c < 100; c++) begin
      step();
      settles += int'(set_d);
      vectors++;
      if ({out_d, busy_d, set_d, out_s, busy_s, set_s} !== {m_cur[0], m_cur[1]}) begin
        miscompares++;
        $display("FAIL reversal c=%0d got %b want %b", c,
                 {out_d, busy_d, set_d, out_s, busy_s, set_s}, {m_cur[0], m_cur[1]});
      end
    end
    vectors++;
    if (settles != 1 || out_d !== 1'b0) begin
      miscompares++;
      $display("FAIL reversal_final got settles=%0d out=%b want 1 0", settles, out_d);
    end
  endtask

  task automatic test_random();
    for (int e = 0; e < 50; e++) begin
      int settles = 0;
      levelIn  = ~levelIn;
      bounceEn = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < 100; c++) begin
        step();
        // Wiggling bounceEn between edges must not disturb the bounce.
        if ($urandom_range(0, 7) == 0) bounceEn = $urandom_range(0, 1);
        settles += int'(set_d);
        vectors++;
        if ({out_d, busy_d, set_d, out_s, busy_s, set_s} !== {m_cur[0], m_cur[1]}) begin
          miscompares++;
          $display("FAIL random e=%0d c=%0d got %b want %b", e, c,
                   {out_d, busy_d, set_d, out_s, busy_s, set_s}, {m_cur[0], m_cur[1]});
        end
      end
      vectors++;
      if (settles != 1 || out_d !== levelIn || busy_d !== 1'b0) begin
        miscompares++;
        $display("FAIL random_event e=%0d got settles=%0d out=%b busy=%b want 1 %b 0",
                 e, settles, out_d, busy_d, levelIn);
      end
    end
  endtask

  task automatic test_reset_mid();
    int settles = 0;
    bounceEn = 1'b0; levelIn = 1'b0;
    step(); step();
    bounceEn = 1'b1; levelIn = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    step();
    vectors++;
    if ({out_d, busy_d, set_d, out_s, busy_s, set_s} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_mid got %b want 000000",
               {out_d, busy_d, set_d, out_s, busy_s, set_s});
    end
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      settles += int'(set_d);
      vectors++;
      if ({out_d, busy_d, set_d, out_s, busy_s, set_s} !== {m_cur[0], m_cur[1]}) begin
        miscompares++;
        $display("FAIL reset_mid c=%0d got %b want %b", c,
                 {out_d, busy_d, set_d, out_s, busy_s, set_s}, {m_cur[0], m_cur[1]});
      end
    end
    vectors++;
    if (settles != 1 || out_d !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_final got settles=%0d out=%b want 1 1", settles, out_d);
    end
  endtask

  task automatic test_seed_zero();
    rst = 1'b1; bounceEn = 1'b0; levelIn = 1'b0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 65535; c++) begin
      step();
      vectors++;
      if (dut_z.lfsr !== m_l[2] || dut_z.lfsr == 16'h0000) begin
        miscompares++;
        $display("FAIL seed_zero_lfsr c=%0d got %h want %h", c, dut_z.lfsr, m_l[2]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bounceEn = 1'b0; levelIn = 1'b0;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_small();
    test_reset_release();
    test_reversal();
    test_random();
    test_reset_mid();
    test_seed_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
